// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select and load-use stall generation for the in-order pipeline.
// A shadow pipe of in-flight destinations runs in lockstep with the datapath; stage 1 is youngest.
module fwd_hazard_unit #(
  parameter int unsigned RW         = 5,
  parameter int unsigned NSRC       = 2,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned SELW      = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [NSRC*RW-1:0]   id_rs,
  input  logic [RW-1:0]        id_rd,
  input  logic                 id_reg_write,
  input  logic                 id_is_load,
  input  logic                 flush,
  output logic [NSRC*SELW-1:0] fwd_sel,
  output logic                 stall,
  output logic [CNT_W-1:0]     stall_count
);

  logic [DEPTH-1:0]     vld_q, vld_d;
  logic [DEPTH-1:0]     ld_q, ld_d;
  logic [RW-1:0]        rd_q [DEPTH];
  logic [RW-1:0]        rd_d [DEPTH];
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NSRC*SELW-1:0] sel_raw;
  logic [NSRC-1:0]      haz_op;
  logic                 stall_c;

  always_comb begin
    sel_raw = '0;
    haz_op  = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      // Scan oldest to youngest so the youngest match overwrites earlier ones.
      for (int unsigned k = DEPTH; k > 0; k--) begin
        if (vld_q[k-1] && (rd_q[k-1] == id_rs[i*RW +: RW]) &&
            !((ZERO_REG != 0) && (id_rs[i*RW +: RW] == '0))) begin
          sel_raw[i*SELW +: SELW] = SELW'(k);
          haz_op[i]               = ld_q[k-1] && (k < LOAD_READY);
        end
      end
    end
    stall_c = id_valid && !flush && (|haz_op);
  end

  assign stall       = stall_c;
  assign fwd_sel     = (stall_c || !id_valid) ? '0 : sel_raw;
  assign stall_count = cnt_q;

  always_comb begin
    vld_d    = '0;
    ld_d     = '0;
    rd_d[0]  = id_rd;
    ld_d[0]  = id_is_load;
    vld_d[0] = id_valid && id_reg_write && !flush && !stall_c &&
               !((ZERO_REG != 0) && (id_rd == '0));
    for (int unsigned k = 1; k < DEPTH; k++) begin
      vld_d[k] = vld_q[k-1];
      ld_d[k]  = ld_q[k-1];
      rd_d[k]  = rd_q[k-1];
    end
    cnt_d = (stall_c && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      ld_q  <= '0;
      cnt_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        rd_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      ld_q  <= ld_d;
      cnt_q <= cnt_d;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        rd_q[k] <= rd_d[k];
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed vector bench for fwd_hazard_unit: forwarding selects, load-use stalls,
// flush, zero register, asynchronous reset and stall counter saturation.
module tb_fwd_hazard_unit;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_is_load;
  logic        flush;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [15:0] stall_count;
  logic [3:0]  sat_fwd_sel;
  logic        sat_stall;
  logic [1:0]  sat_count;

  int errors = 0;
  int checks = 0;

  fwd_hazard_unit u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
    .fwd_sel(fwd_sel), .stall(stall), .stall_count(stall_count)
  );

  fwd_hazard_unit #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
    .fwd_sel(sat_fwd_sel), .stall(sat_stall), .stall_count(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs0, rs1, rd;
    logic       wr, ld, fl;
    logic       st;
    logic [1:0] e0, e1;
  } vec_t;

  vec_t tbl [32];

  function automatic vec_t mk(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                              input logic [4:0] rd, input logic wr, input logic ld,
                              input logic fl, input logic st, input logic [1:0] e0,
                              input logic [1:0] e1);
    vec_t r;
    r.v = v; r.rs0 = rs0; r.rs1 = rs1; r.rd = rd; r.wr = wr; r.ld = ld; r.fl = fl;
    r.st = st; r.e0 = e0; r.e1 = e1;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [4:0] rd, input logic wr, input logic ld, input logic fl);
    id_valid = v; id_rs = {rs1, rs0}; id_rd = rd;
    id_reg_write = wr; id_is_load = ld; flush = fl;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int exp_stalls;
    //               v rs0 rs1 rd wr ld fl  st e0 e1
    tbl[0]  = mk(1, 5,  7,  0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1,  2,  5, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 5,  0,  0, 0, 0, 0, 0, 1, 0);
    tbl[3]  = mk(1, 9,  9,  5, 1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 5,  5,  0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 5,  3,  0, 0, 0, 0, 0, 2, 0);
    tbl[6]  = mk(1, 5,  0,  0, 0, 0, 0, 0, 3, 0);
    tbl[7]  = mk(1, 5,  0,  0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 0,  0,  5, 1, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 0,  0,  5, 1, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 4,  5,  0, 0, 0, 0, 0, 0, 1);
    tbl[11] = mk(1, 5,  5,  5, 1, 0, 0, 0, 2, 2);
    tbl[12] = mk(1, 5,  5,  0, 0, 0, 0, 0, 1, 1);
    tbl[13] = mk(0, 0,  0,  0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 0,  0,  0, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(1, 0,  0,  7, 1, 1, 0, 0, 0, 0);
    tbl[16] = mk(1, 7,  0,  8, 1, 0, 0, 1, 0, 0);
    tbl[17] = mk(1, 7,  0,  8, 1, 0, 0, 0, 2, 0);
    tbl[18] = mk(1, 8,  0,  7, 1, 1, 0, 0, 1, 0);
    tbl[19] = mk(1, 3,  4,  0, 0, 0, 0, 0, 0, 0);
    tbl[20] = mk(1, 0,  0,  6, 1, 1, 0, 0, 0, 0);
    tbl[21] = mk(1, 2,  6,  0, 0, 0, 0, 1, 0, 0);
    tbl[22] = mk(1, 2,  6,  0, 0, 0, 0, 0, 0, 2);
    tbl[23] = mk(1, 0,  0,  0, 1, 0, 0, 0, 0, 0);
    tbl[24] = mk(1, 0,  0,  0, 1, 1, 0, 0, 0, 0);
    tbl[25] = mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 0);
    tbl[26] = mk(1, 0,  0,  3, 1, 0, 1, 0, 0, 0);
    tbl[27] = mk(1, 3,  0,  0, 0, 0, 0, 0, 0, 0);
    tbl[28] = mk(1, 0,  0,  9, 1, 1, 0, 0, 0, 0);
    tbl[29] = mk(1, 9,  0, 10, 1, 0, 1, 0, 1, 0);
    tbl[30] = mk(1, 10, 9,  0, 0, 0, 0, 0, 0, 2);
    tbl[31] = mk(0, 0,  0,  0, 0, 0, 0, 0, 0, 0);

    rst_n = 1'b0;
    drive(1, 5, 7, 5, 1, 1, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset stall", 32'(stall), 0);
    chk("reset fwd_sel", 32'(fwd_sel), 0);
    chk("reset stall_count", 32'(stall_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);

    exp_stalls = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].rs0, tbl[i].rs1, tbl[i].rd, tbl[i].wr, tbl[i].ld, tbl[i].fl);
      #1;
      chk($sformatf("vec%0d stall", i), 32'(stall), 32'(tbl[i].st));
      chk($sformatf("vec%0d sel0", i), 32'(fwd_sel[1:0]), 32'(tbl[i].e0));
      chk($sformatf("vec%0d sel1", i), 32'(fwd_sel[3:2]), 32'(tbl[i].e1));
      if (tbl[i].st) exp_stalls++;
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("table stall_count", 32'(stall_count), 32'(exp_stalls));
    chk("table sat_count", 32'(sat_count), 32'(exp_stalls));

    // Asynchronous reset in the middle of a pending load-use stall
    @(negedge clk);
    drive(1, 0, 0, 7, 1, 1, 0);
    @(negedge clk);
    drive(1, 7, 0, 0, 0, 0, 0);
    #1;
    chk("pre-reset stall", 32'(stall), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset stall", 32'(stall), 0);
    chk("async reset fwd_sel", 32'(fwd_sel), 0);
    chk("async reset stall_count", 32'(stall_count), 0);
    chk("async reset sat_count", 32'(sat_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset stall", 32'(stall), 0);
    chk("post-reset fwd_sel", 32'(fwd_sel), 0);

    // Back-to-back dependent loads: stall on every other cycle, five stalls total
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      drive(1, 7, 0, 7, 1, 1, 0);
      #1;
      chk($sformatf("sat seq%0d stall", n), 32'(stall), 32'(n % 2));
      if (n == 2) chk("sat seq2 sel0", 32'(fwd_sel[1:0]), 2);
      if (n == 4) chk("sat seq4 count", 32'(sat_count), 2);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("stall_count 16b", 32'(stall_count), 5);
    chk("stall_count saturated", 32'(sat_count), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised operand-forwarding and load-use hazard unit for the in-order integer pipeline.
- Keeps its own shadow pipeline of in-flight destination registers, DEPTH stages deep, advanced in lockstep with the datapath.
- For each of NSRC source operands of the instruction entering EX, selects the youngest in-flight producer.
- Raises a one-cycle-granular stall when that producer is a load whose data is not yet forwardable.
- Keeps a saturating count of stall cycles for performance monitoring.

Parameters:
- RW, 5: register address width.
- NSRC, 2: number of source operands per instruction.
- DEPTH, 3: number of forwarding stages tracked. Stage 1 is the youngest (EX/MEM); stage DEPTH is the oldest (last stage before register-file write).
- LOAD_READY, 2: lowest stage index at which load data is forwardable; range 1..DEPTH.
- ZERO_REG, 1: 1 means register 0 is hardwired zero and is never forwarded or tracked.
- CNT_W, 16: stall counter width.
- Derived, not overridable: SELW = $clog2(DEPTH+1).

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- id_valid, input, 1: valid instruction is entering EX this cycle.
- id_rs, input, NSRC*RW: source register addresses, flattened; operand i occupies bits [i*RW +: RW].
- id_rd, input, RW: destination register of the entering instruction.
- id_reg_write, input, 1: entering instruction writes id_rd.
- id_is_load, input, 1: entering instruction is a load.
- flush, input, 1: kill the entering instruction; it must not enter the shadow pipe.
- fwd_sel, output, NSRC*SELW: per-operand select, flattened. 0 = register file; k = stage k.
- stall, output, 1: hold the entering instruction and insert a bubble.
- stall_count, output, CNT_W: saturating count of cycles with stall=1.

Behaviour:
- Shadow pipe entry k holds {vld_k, rd_k, ld_k}. Reset clears every vld_k, rd_k and ld_k to 0.
- Entry written into stage 1:
  - vld = id_valid & id_reg_write & ~flush & ~stall & ~(ZERO_REG & id_rd==0).
  - rd and ld are captured from id_rd and id_is_load.
  - The entry is a bubble (vld=0) on flush or stall.
- Stages 2..DEPTH always shift (stage k <= stage k-1) every cycle, regardless of stall or flush.
- Match for operand i at stage k: vld_k & rd_k==rs_i & ~(ZERO_REG & rs_i==0).
- Youngest match wins: the lowest k among matching stages. With no match, the operand selects the register file.
- Load-use hazard for operand i: the youngest matching stage k has ld_k=1 and k < LOAD_READY.
- stall = id_valid & ~flush & (hazard on any operand). It is combinational, with no register between the inputs and stall/fwd_sel.
- fwd_sel_i is the youngest matching k, or 0 if none.
  - fwd_sel is forced to all zeros whenever stall=1 or id_valid=0.
- A stalled instruction is re-presented by the upstream on following cycles with the same inputs. Stall deasserts once the load reaches stage LOAD_READY. Stall length is exactly LOAD_READY - k cycles.
- flush and stall in the same cycle: flush wins, stall=0, and a bubble enters stage 1.
- stall_count increments by 1 on each clock edge where stall=1, and saturates at all-ones.
- Reset behaviour:
  - Any rst_n low asynchronously clears the pipe and stall_count.
  - With an empty pipe, outputs follow the inputs combinationally: fwd_sel=0 and stall=0 whatever the id_* inputs.
  - Reset mid-stall discards the pending hazard.
- Simultaneous writers of the same rd in several stages: only the youngest is selected. Older entries are not invalidated; they age out naturally.
- A source equal to id_rd of the same entering instruction is not a self-hazard.

Test Plan:
1. Defaults DEPTH=3, LOAD_READY=2. ALU writes r5 at cycle t, next instruction reads rs0=r5 at t+1 -> fwd_sel[0]=1, stall=0. Reading r5 at t+2 instead -> sel=2; at t+4 -> sel=0.
2. Write r5 at t and again at t+1, read rs1=r5 at t+2 -> fwd_sel[1]=1 (youngest), not 2. Both operands reading r5 -> both sel=1.
3. Load to r7 at t, dependent reads r7 at t+1:
   - t+1: stall=1, fwd_sel=0.
   - t+2: same instruction re-presented -> stall=0, sel=2.
   - stall_count=1.
   - Independent instruction at t+1 -> stall=0.
4. Write r0 (ZERO_REG=1), then read r0 -> sel=0, no stall. A load to r0 followed by a read of r0 -> no stall.
5. Flush asserted with a write to r3 entering at t, read r3 at t+1 -> sel=0. Flush concurrent with a load-use hazard -> stall=0, bubble inserted.
6. Mid-operation reset: pipe full and stall=1, pull rst_n low asynchronously mid-cycle -> stall=0, fwd_sel=0, stall_count=0 immediately. With CNT_W=2, 5 stall cycles -> stall_count=3 (saturated).
